// File: rtl/fifo_stream_ctrl.sv
// fifo_stream_ctrl: sits between a word producer and a fixed-rate sample
// consumer. It primes the watermark FIFO, then issues paced single-cycle
// pops, latches each popped word as a sample, and flags starvation.
//
// Producer handshake: a word transfers on a rising clk edge when
// src_valid & src_ready are both high. src_ready never depends on src_valid,
// and the producer must hold src_data stable while src_valid is high and
// src_ready is low.
module fifo_stream_ctrl #(
  parameter int WRITE_W = 16,
  parameter int READ_W  = 24,
  parameter int CLK_DIV = 1042,
  parameter int SETTLE  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [WRITE_W-1:0] src_data,
  output logic               fifo_we,
  output logic [WRITE_W-1:0] fifo_din,
  output logic               fifo_clear,
  output logic               fifo_pop_front,
  input  logic [READ_W-1:0]  fifo_dout,
  input  logic               fifo_buf_hw,
  input  logic               fifo_buf_lw,
  output logic [READ_W-1:0]  sample_out,
  output logic               sample_valid,
  output logic               refill_irq,
  output logic [15:0]        underrun_cnt,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int SETTLE_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE);
  localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);

  state_t              r_state;
  logic [SETTLE_W-1:0] r_settle;
  logic [15:0]         r_tick;
  logic [READ_W-1:0]   r_sample;
  logic                r_sample_valid;
  logic                r_pop;
  logic [15:0]         r_underrun_cnt;

  logic w_settling;
  logic w_tick;

  assign w_settling = (r_settle != '0);
  assign w_tick     = (r_state == RUN) && (r_tick == TICK_LAST);

  // Producer-side decode: flags are ignored while the settle window runs
  // because they still reflect the FIFO contents from before the clear.
  always_comb begin
    src_ready = 1'b0;
    case (r_state)
      PRIME:   src_ready = w_settling | ~fifo_buf_hw;
      RUN:     src_ready = ~fifo_buf_hw;
      default: src_ready = 1'b0;
    endcase
  end

  assign fifo_we        = src_valid & src_ready;
  assign fifo_din       = src_data;
  assign fifo_clear     = (r_state == IDLE);
  assign refill_irq     = (r_state == RUN) & fifo_buf_lw;
  assign fifo_pop_front = r_pop;
  assign sample_valid   = r_sample_valid;
  assign sample_out     = r_sample;
  assign underrun_cnt   = r_underrun_cnt;
  assign state_o        = r_state;

  // Sequencing FSM with registered pop/sample strobes and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_settle       <= '0;
      r_tick         <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_pop          <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_sample_valid <= 1'b0;
      r_pop          <= 1'b0;
      if (!enable) begin
        // Stopping drops any pop that would have fired this cycle.
        r_state  <= IDLE;
        r_settle <= '0;
        r_tick   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= PRIME;
            r_settle <= SETTLE_LOAD;
          end
          PRIME: begin
            if (w_settling) begin
              r_settle <= r_settle - 1'b1;
            end else if (fifo_buf_hw) begin
              r_state <= RUN;
              r_tick  <= '0;
            end
          end
          RUN: begin
            if (w_tick) begin
              r_tick         <= '0;
              r_sample       <= fifo_dout;
              r_sample_valid <= 1'b1;
              r_pop          <= 1'b1;
              if (fifo_buf_lw && !src_valid && (r_underrun_cnt != 16'hFFFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
              end
            end else begin
              r_tick <= r_tick + 16'd1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// Bench for fifo_stream_ctrl: randomized and directed stimulus compared with
// a behavioural model built from the block's rules (sample schedule by
// modulo arithmetic, samples tracked through an expected queue).
module tb_fifo_stream_ctrl;

  localparam int WRITE_W = 16;
  localparam int READ_W  = 24;
  localparam int CLK_DIV = 4;
  localparam int SETTLE  = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               enable = 1'b0;
  logic               src_valid = 1'b0;
  logic               src_ready;
  logic [WRITE_W-1:0] src_data = '0;
  logic               fifo_we;
  logic [WRITE_W-1:0] fifo_din;
  logic               fifo_clear;
  logic               fifo_pop_front;
  logic [READ_W-1:0]  fifo_dout = '0;
  logic               fifo_buf_hw = 1'b0;
  logic               fifo_buf_lw = 1'b0;
  logic [READ_W-1:0]  sample_out;
  logic               sample_valid;
  logic               refill_irq;
  logic [15:0]        underrun_cnt;
  logic [1:0]         state_o;

  fifo_stream_ctrl #(
    .WRITE_W(WRITE_W), .READ_W(READ_W), .CLK_DIV(CLK_DIV), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .fifo_we(fifo_we), .fifo_din(fifo_din), .fifo_clear(fifo_clear),
    .fifo_pop_front(fifo_pop_front), .fifo_dout(fifo_dout),
    .fifo_buf_hw(fifo_buf_hw), .fifo_buf_lw(fifo_buf_lw),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .refill_irq(refill_irq), .underrun_cnt(underrun_cnt), .state_o(state_o)
  );

  // Scoreboard and counters
  int n_checks = 0;
  int n_fail = 0;
  logic [READ_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 prime, 2 run
  int          m_state;
  int          m_settle;
  int          m_runc;
  logic        m_pulse;
  logic [READ_W-1:0] m_sample;
  int          m_under;
  logic        prev_pop;
  int          wr_cnt;
  logic        hw_d1, hw_d2;

  function automatic logic exp_ready();
    if (m_state == 1) return (m_settle != 0) || !fifo_buf_hw;
    if (m_state == 2) return !fifo_buf_hw;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_settle = 0; m_runc = 0; m_pulse = 1'b0;
    m_sample = '0; m_under = 0; prev_pop = 1'b0;
    exp_q.delete();
  endtask

  // Advances the model across one rising edge using the inputs held there.
  task automatic model_edge();
    logic rdy;
    rdy = exp_ready();
    if (src_valid && rdy) wr_cnt++;
    hw_d2 = hw_d1;
    hw_d1 = (wr_cnt >= 24);
    m_pulse = 1'b0;
    if (!enable) begin
      m_state = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_settle = SETTLE;
    end else if (m_state == 1) begin
      if (m_settle > 0) m_settle--;
      else if (fifo_buf_hw) begin m_state = 2; m_runc = 0; end
    end else begin
      m_runc++;
      if (m_runc % CLK_DIV == 0) begin
        m_pulse = 1'b1;
        m_sample = fifo_dout;
        exp_q.push_back(fifo_dout);
        if (fifo_buf_lw && !src_valid && m_under < 16'hFFFF) m_under++;
      end
    end
  endtask

  // One cycle: inputs were driven at the preceding negedge.
  task automatic step();
    #1;
    check("src_ready", src_ready, exp_ready());
    check("fifo_we", fifo_we, src_valid & exp_ready());
    check("fifo_din", fifo_din, src_data);
    check("fifo_clear", fifo_clear, m_state == 0);
    check("refill_irq", refill_irq, (m_state == 2) && fifo_buf_lw);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("state_o", state_o, m_state);
    check("sample_valid", sample_valid, m_pulse);
    check("pop_front", fifo_pop_front, m_pulse);
    check("pop_b2b", prev_pop & fifo_pop_front, 1'b0);
    prev_pop = fifo_pop_front;
    check("underrun_cnt", underrun_cnt, m_under);
    check("sample_out", sample_out, m_sample);
    if (sample_valid) begin
      if (exp_q.size() == 0) check("sb_unexpected", exp_q.size(), 1);
      else check("sb_sample", sample_out, exp_q.pop_front());
    end
  endtask

  // Driver helpers
  task automatic drive_rand();
    src_valid   = 1'($urandom_range(0, 1));
    src_data    = 16'($urandom);
    fifo_dout   = 24'($urandom);
    fifo_buf_hw = 1'($urandom_range(0, 1));
    fifo_buf_lw = ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_run(input string tag);
    int cyc;
    cyc = 0;
    while (state_o != 2'd2 && cyc < 200) begin
      step();
      cyc++;
    end
    check(tag, state_o, 2'd2);
  endtask

  initial begin
    int settle_cnt;
    model_reset();
    wr_cnt = 0; hw_d1 = 1'b0; hw_d2 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", state_o, 2'd0);
    check("rst_clear", fifo_clear, 1'b1);
    check("rst_pop", fifo_pop_front, 1'b0);
    check("rst_sv", sample_valid, 1'b0);
    check("rst_under", underrun_cnt, 16'd0);
    check("rst_sample", sample_out, 24'd0);
    rst_n = 1'b1;
    step();

    // Prime with a producer always offering data; hw follows the write
    // count with two cycles of lag.
    enable = 1'b1; src_valid = 1'b1;
    begin
      int cyc;
      cyc = 0;
      while (state_o != 2'd2 && cyc < 200) begin
        fifo_buf_hw = hw_d2;
        src_data = 16'($urandom);
        step();
        cyc++;
      end
      check("prime_run", state_o, 2'd2);
      check("prime_writes_ge24", wr_cnt >= 24, 1'b1);
    end

    // Starvation: five ticks with lw high and no producer word.
    src_valid = 1'b0; fifo_buf_hw = 1'b0; fifo_buf_lw = 1'b1;
    fifo_dout = 24'h123456;
    repeat (5 * CLK_DIV) step();
    check("underrun_5", underrun_cnt, 16'd5);
    check("refill_lw", refill_irq, 1'b1);

    // Fixed head word
    fifo_buf_lw = 1'b0; src_valid = 1'b1; fifo_dout = 24'hABCDEF;
    repeat (3 * CLK_DIV) step();
    check("sample_abcdef", sample_out, 24'hABCDEF);

    // hw toggling: ready tracks ~hw, no writes while not ready
    for (int i = 0; i < 6; i++) begin
      fifo_buf_hw = i[0];
      step();
    end

    // Randomized run
    for (int i = 0; i < 150; i++) begin
      drive_rand();
      step();
    end

    // Disable mid-run, then re-enable with hw high: exactly SETTLE ready
    // cycles in PRIME.
    enable = 1'b0;
    step();
    check("dis_state", state_o, 2'd0);
    check("dis_clear", fifo_clear, 1'b1);
    check("dis_ready", src_ready, 1'b0);
    step();
    enable = 1'b1; fifo_buf_hw = 1'b1; src_valid = 1'b0;
    settle_cnt = 0;
    begin
      int cyc;
      cyc = 0;
      while (state_o != 2'd2 && cyc < 50) begin
        step();
        if (state_o == 2'd1 && src_ready) settle_cnt++;
        cyc++;
      end
    end
    check("settle_cycles", settle_cnt, SETTLE);
    check("reprime_run", state_o, 2'd2);

    // Saturation: counter preloaded to FFFE while idle
    enable = 1'b0; fifo_buf_hw = 1'b0;
    step();
    force dut.r_underrun_cnt = 16'hFFFE;
    m_under = 16'hFFFE;
    step();
    release dut.r_underrun_cnt;
    step();
    check("preload", underrun_cnt, 16'hFFFE);
    enable = 1'b1; fifo_buf_hw = 1'b1;
    wait_run("sat_run");
    fifo_buf_hw = 1'b0; fifo_buf_lw = 1'b1; src_valid = 1'b0;
    repeat (3 * CLK_DIV) step();
    check("sat_ffff", underrun_cnt, 16'hFFFF);
    repeat (2 * CLK_DIV + 1) step();
    check("sat_hold", underrun_cnt, 16'hFFFF);

    // Asynchronous reset between edges while running
    fifo_buf_lw = 1'b0; src_valid = 1'b1;
    repeat (CLK_DIV - 1) step();
    #3 rst_n = 1'b0;
    #1;
    check("arst_state", state_o, 2'd0);
    check("arst_clear", fifo_clear, 1'b1);
    check("arst_pop", fifo_pop_front, 1'b0);
    check("arst_sv", sample_valid, 1'b0);
    check("arst_under", underrun_cnt, 16'd0);
    model_reset();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("end_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_ctrl.md
Name: fifo_stream_ctrl

Overview:
- Sequences the watermark FIFO between a word producer (host/DMA writer) and a fixed-rate sample consumer (audio output path).
- Gates producer writes with a valid/ready handshake driven by the high watermark.
- Primes the FIFO before playback, issues paced single-cycle pop strobes, latches each popped word as an output sample.
- Raises a refill request on low watermark and counts starvation events.

Parameters:
- WRITE_W, 16, producer/FIFO write word width
- READ_W, 24, FIFO read word / sample width
- CLK_DIV, 1042, clk cycles per sample tick (50 MHz / 48 kHz); legal range 4..65535
- SETTLE, 3, cycles after leaving clear during which FIFO watermark flags are ignored

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = stream active, 0 = stop and flush
- src_valid  in  1  producer has a word on src_data
- src_ready  out  1  controller accepts a word this cycle
- src_data  in  WRITE_W  producer word
- fifo_we  out  1  FIFO write enable = src_valid & src_ready (combinational)
- fifo_din  out  WRITE_W  = src_data (combinational)
- fifo_clear  out  1  synchronous FIFO clear, high in IDLE
- fifo_pop_front  out  1  single-cycle pop strobe
- fifo_dout  in  READ_W  FIFO head word (registered inside FIFO)
- fifo_buf_hw  in  1  FIFO high watermark
- fifo_buf_lw  in  1  FIFO low watermark
- sample_out  out  READ_W  last latched sample
- sample_valid  out  1  one-cycle pulse when sample_out updates
- refill_irq  out  1  level refill request to CPU
- underrun_cnt  out  16  saturating starvation counter
- state_o  out  2  IDLE=0, PRIME=1, RUN=2

Behaviour:
- Reset (rst_n low, async): state IDLE, settle counter 0, tick counter 0, sample_out 0, sample_valid 0, fifo_pop_front 0, underrun_cnt 0. fifo_clear reads 1 during reset because it decodes IDLE.
- Any state, enable=0: next state IDLE. Reset or disable mid-RUN drops any pending pop; no sample_valid is produced.
- IDLE:
  - fifo_clear=1, src_ready=0, no pops, refill_irq=0.
  - enable=1 -> PRIME; settle counter loads SETTLE.
  - underrun_cnt holds its value in IDLE and clears only on reset.
- PRIME:
  - fifo_clear=0, no pops.
  - src_ready=1 while settle counter nonzero or fifo_buf_hw=0, else 0.
  - Settle counter decrements each cycle to 0, because FIFO flags lag clear/writes by 2 cycles.
  - When settle counter=0 and fifo_buf_hw=1 -> RUN; tick counter set to 0.
- RUN:
  - src_ready = ~fifo_buf_hw; refill_irq = fifo_buf_lw.
  - Tick counter counts 0..CLK_DIV-1 and wraps.
  - At count CLK_DIV-1 (the tick): sample_out <= fifo_dout, sample_valid=1, fifo_pop_front=1, each for exactly that one cycle. The first tick is CLK_DIV cycles after entering RUN.
  - Pops are never asserted on consecutive cycles; CLK_DIV>=4 guarantees this, since the FIFO ignores back-to-back pop levels.
  - Tick with fifo_buf_lw=1 and src_valid=0: underrun_cnt += 1, saturating at 16'hFFFF. The pop still occurs; no state change.
- Watermark lag: up to 2 extra words may be written after hw rises. This is accepted; the FIFO's hw margin covers it.
- Simultaneous write and pop in the same cycle are independent; both proceed.

Test Plan:
- Reset with rst_n=0 mid-RUN (async, between clock edges) -> state_o=0, fifo_clear=1, pop/sample_valid=0, underrun_cnt=0 immediately.
- enable=1, src_valid held 1, hw model rises after 24 writes:
  - first 3 PRIME cycles have src_ready=1 regardless of hw;
  - src_ready falls within 1 cycle of hw;
  - RUN is entered.
- RUN with CLK_DIV=4, fifo_dout=24'hABCDEF at tick:
  - sample_out=24'hABCDEF, sample_valid and fifo_pop_front pulse once every 4 cycles;
  - never high on two consecutive cycles.
- RUN, fifo_buf_lw=1, src_valid=0 for 5 ticks -> refill_irq=1, underrun_cnt=5. With the counter preloaded to 16'hFFFE, 3 such ticks -> 16'hFFFF.
- enable dropped mid-RUN -> next cycle state_o=0, fifo_clear=1, src_ready=0. Re-enable -> PRIME with settle count restarting at 3.
- RUN, fifo_buf_hw toggles 0->1->0 -> src_ready tracks ~fifo_buf_hw combinationally; fifo_we=0 whenever src_ready=0.
